simd_operand_fetch: RTL and testbench

//   Operand-fetch stage directly upstream of the simd lane array. Holds a line memory of
//   2*DATA_W-bit entries; on a start command, walks a run of lanes and, per lane, reads one

---
 rtl/simd_operand_fetch.sv | 126 ++++++++++++
 tb/tb_simd_operand_fetch.sv | 432 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/simd_operand_fetch.sv
// Operand-fetch stage ahead of the simd lane array: walks a run of lines from a local
// line memory and issues {lane, opcode, A, B} beats over a valid/ready handshake.
module simd_operand_fetch #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4,
    parameter int DEPTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [ADDR_W-1:0]     wr_addr,
    input  logic [2*DATA_W-1:0]   wr_data,
    input  logic                  start,
    input  logic [1:0]            opcode_in,
    input  logic [ADDR_W-1:0]     first_lane,
    input  logic [ADDR_W:0]       lane_count,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ADDR_W-1:0]     out_lane,
    output logic [1:0]            out_opcode,
    output logic [DATA_W-1:0]     out_a,
    output logic [DATA_W-1:0]     out_b,
    output logic                  out_last,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_ISSUE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [1:0]        OP_RSVD  = 2'b11;
    localparam logic [ADDR_W-1:0] LANE_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W:0]   CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};

    state_t                 state_reg, state_next;
    logic [2*DATA_W-1:0]    mem [DEPTH];
    logic [2*DATA_W-1:0]    rd_data_reg;
    logic [ADDR_W-1:0]      lane_reg;
    logic [ADDR_W:0]        remaining_reg;
    logic [1:0]             opcode_reg;
    logic                   err_reg;
    logic                   accept;
    logic                   handshake;

    assign accept    = (state_reg == S_IDLE) && start && (opcode_in != OP_RSVD);
    assign handshake = (state_reg == S_ISSUE) && out_ready;

    // Line memory is deliberately left out of reset so its contents survive an abort.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Registered read happens only in READ, so a same-cycle write yields the old line
    // and later writes cannot disturb a beat that is already being held.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_data_reg <= '0;
        end else if (state_reg == S_READ) begin
            rd_data_reg <= mem[lane_reg];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE: begin
                if (accept) begin
                    state_next = (lane_count == '0) ? S_DONE : S_READ;
                end
            end
            S_READ:  state_next = S_ISSUE;
            S_ISSUE: begin
                if (out_ready) begin
                    state_next = (remaining_reg == CNT_ONE) ? S_DONE : S_READ;
                end
            end
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lane_reg      <= '0;
            remaining_reg <= '0;
            opcode_reg    <= '0;
            err_reg       <= 1'b0;
        end else begin
            err_reg <= (state_reg == S_IDLE) && start && (opcode_in == OP_RSVD);
            if (accept) begin
                opcode_reg    <= opcode_in;
                lane_reg      <= first_lane;
                remaining_reg <= lane_count;
            end else if (handshake) begin
                remaining_reg <= remaining_reg - CNT_ONE;
                lane_reg      <= lane_reg + LANE_ONE;
            end
        end
    end

    assign out_valid  = (state_reg == S_ISSUE);
    assign out_last   = (state_reg == S_ISSUE) && (remaining_reg == CNT_ONE);
    assign out_lane   = lane_reg;
    assign out_opcode = opcode_reg;
    assign out_a      = rd_data_reg[2*DATA_W-1:DATA_W];
    assign out_b      = rd_data_reg[DATA_W-1:0];
    assign busy       = (state_reg != S_IDLE);
    assign done       = (state_reg == S_DONE);
    assign err        = err_reg;

endmodule

// File: tb/tb_simd_operand_fetch.sv
// Bench for simd_operand_fetch: directed scenarios plus randomized runs checked against
// a line-memory model that predicts the beat sequence of each run.
module tb_simd_operand_fetch;

    localparam int DW = 16;
    localparam int AW = 4;
    localparam int NL = 16;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            wr_en = 1'b0;
    logic [AW-1:0]   wr_addr = '0;
    logic [2*DW-1:0] wr_data = '0;
    logic            start = 1'b0;
    logic [1:0]      opcode_in = '0;
    logic [AW-1:0]   first_lane = '0;
    logic [AW:0]     lane_count = '0;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [AW-1:0]   out_lane;
    logic [1:0]      out_opcode;
    logic [DW-1:0]   out_a;
    logic [DW-1:0]   out_b;
    logic            out_last;
    logic            busy;
    logic            done;
    logic            err;

    simd_operand_fetch #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(NL)) dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .start(start), .opcode_in(opcode_in), .first_lane(first_lane),
        .lane_count(lane_count), .out_valid(out_valid), .out_ready(out_ready),
        .out_lane(out_lane), .out_opcode(out_opcode), .out_a(out_a), .out_b(out_b),
        .out_last(out_last), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [AW-1:0] lane;
        logic [1:0]    op;
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic          last;
    } beat_t;

    int          tests_run = 0;
    int          tests_failed = 0;
    logic [31:0] model_mem [NL];
    beat_t       got_q [$];
    beat_t       exp_q [$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_line(input int idx, input logic [31:0] d);
        wr_en   = 1'b1;
        wr_addr = idx[AW-1:0];
        wr_data = d;
        tick();
        wr_en = 1'b0;
        model_mem[idx] = d;
    endtask

    // Expected beats of a run: consecutive lanes modulo the memory size, last on the final one.
    task automatic build_exp(input int first, input int count, input logic [1:0] op);
        beat_t e;
        exp_q.delete();
        for (int i = 0; i < count; i++) begin
            e.lane = AW'((first + i) % NL);
            e.op   = op;
            e.a    = model_mem[(first + i) % NL][31:16];
            e.b    = model_mem[(first + i) % NL][15:0];
            e.last = (i == count - 1);
            exp_q.push_back(e);
        end
    endtask

    task automatic run_cmd(input int first, input int count, input logic [1:0] op,
                           input int pct, output int done_cnt, output bit timeout);
        beat_t b;
        bit    hs;
        got_q.delete();
        done_cnt   = 0;
        timeout    = 1'b1;
        start      = 1'b1;
        opcode_in  = op;
        first_lane = first[AW-1:0];
        lane_count = count[AW:0];
        for (int cyc = 0; cyc < 400; cyc++) begin
            out_ready = ($urandom_range(0, 99) < pct);
            hs     = out_valid && out_ready;
            b.lane = out_lane;
            b.op   = out_opcode;
            b.a    = out_a;
            b.b    = out_b;
            b.last = out_last;
            tick();
            start = 1'b0;
            if (hs) got_q.push_back(b);
            if (done) done_cnt++;
            if (done_cnt > 0 && !busy) begin
                timeout = 1'b0;
                break;
            end
        end
        start     = 1'b0;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) tick();
        tests_run++;
        if ({out_valid, busy, done, err, out_last} !== 5'b0) begin
            tests_failed++;
            $display("FAIL reset_flags got=%b exp=00000", {out_valid, busy, done, err, out_last});
        end
        tests_run++;
        if ({out_lane, out_opcode, out_a, out_b} !== '0) begin
            tests_failed++;
            $display("FAIL reset_data got=%h exp=0", {out_lane, out_opcode, out_a, out_b});
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single();
        write_line(3, 32'h0005_0007);
        out_ready  = 1'b1;
        start      = 1'b1;
        opcode_in  = 2'b00;
        first_lane = 4'd3;
        lane_count = 5'd1;
        tick();
        start = 1'b0;
        tests_run++;
        if (out_valid !== 1'b0 || busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL single_read got valid=%b busy=%b exp valid=0 busy=1", out_valid, busy);
        end
        tick();
        tests_run++;
        if ({out_valid, out_lane, out_a, out_b, out_last, out_opcode} !== {1'b1, 4'd3, 16'h0005, 16'h0007, 1'b1, 2'b00}) begin
            tests_failed++;
            $display("FAIL single_beat got v=%b lane=%0d a=%h b=%h last=%b exp v=1 lane=3 a=0005 b=0007 last=1",
                     out_valid, out_lane, out_a, out_b, out_last);
        end
        tick();
        out_ready = 1'b0;
        tests_run++;
        if (done !== 1'b1 || out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL single_done got done=%b valid=%b exp done=1 valid=0", done, out_valid);
        end
        tick();
        tests_run++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL single_idle got done=%b busy=%b exp 0 0", done, busy);
        end
    endtask

    task automatic test_wrap();
        int dc;
        bit to;
        write_line(14, $urandom);
        write_line(15, $urandom);
        write_line(0, $urandom);
        run_cmd(14, 3, 2'b00, 100, dc, to);
        build_exp(14, 3, 2'b00);
        tests_run++;
        if (to || dc != 1 || got_q.size() != 3) begin
            tests_failed++;
            $display("FAIL wrap_count got beats=%0d done=%0d timeout=%0b exp beats=3 done=1 timeout=0",
                     got_q.size(), dc, to);
        end
        for (int i = 0; i < 3 && i < got_q.size(); i++) begin
            tests_run++;
            if (got_q[i] !== exp_q[i]) begin
                tests_failed++;
                $display("FAIL wrap_beat%0d got=%h exp=%h", i, got_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [AW+2*DW:0] hold;
        logic [AW+2*DW:0] want;
        int               waited;
        write_line(5, $urandom);
        write_line(6, $urandom);
        want       = {4'd5, model_mem[5], 1'b0};
        out_ready  = 1'b0;
        start      = 1'b1;
        opcode_in  = 2'b10;
        first_lane = 4'd5;
        lane_count = 5'd2;
        tick();
        start  = 1'b0;
        waited = 0;
        while (!out_valid && waited < 10) begin
            tick();
            waited++;
        end
        hold = {out_lane, out_a, out_b, out_last};
        tests_run++;
        if (!out_valid || hold !== want) begin
            tests_failed++;
            $display("FAIL bp_first got v=%b beat=%h exp v=1 beat=%h", out_valid, hold, want);
        end
        for (int k = 0; k < 5; k++) begin
            if (k == 0) begin
                wr_en   = 1'b1;
                wr_addr = 4'd5;
                wr_data = ~model_mem[5];
            end
            tick();
            wr_en = 1'b0;
            tests_run++;
            if (!out_valid || {out_lane, out_a, out_b, out_last} !== hold) begin
                tests_failed++;
                $display("FAIL bp_hold%0d got v=%b beat=%h exp v=1 beat=%h", k, out_valid,
                         {out_lane, out_a, out_b, out_last}, hold);
            end
        end
        model_mem[5] = ~model_mem[5];
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        tests_run++;
        if (out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL bp_nodup got valid=%b exp 0", out_valid);
        end
        tick();
        want = {4'd6, model_mem[6], 1'b1};
        tests_run++;
        if (!out_valid || {out_lane, out_a, out_b, out_last} !== want) begin
            tests_failed++;
            $display("FAIL bp_second got v=%b beat=%h exp v=1 beat=%h", out_valid,
                     {out_lane, out_a, out_b, out_last}, want);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        tests_run++;
        if (done !== 1'b1) begin
            tests_failed++;
            $display("FAIL bp_done got=%b exp=1", done);
        end
        tick();
    endtask

    task automatic test_err_and_empty();
        out_ready  = 1'b1;
        start      = 1'b1;
        opcode_in  = 2'b11;
        first_lane = 4'd1;
        lane_count = 5'd4;
        tick();
        start = 1'b0;
        tests_run++;
        if ({err, busy, out_valid} !== 3'b100) begin
            tests_failed++;
            $display("FAIL err_pulse got err/busy/valid=%b exp 100", {err, busy, out_valid});
        end
        tick();
        tests_run++;
        if ({err, busy, out_valid, done} !== 4'b0) begin
            tests_failed++;
            $display("FAIL err_clear got err/busy/valid/done=%b exp 0000", {err, busy, out_valid, done});
        end
        start      = 1'b1;
        opcode_in  = 2'b01;
        lane_count = 5'd0;
        tick();
        start = 1'b0;
        tests_run++;
        if ({done, out_valid, err} !== 3'b100) begin
            tests_failed++;
            $display("FAIL empty_done got done/valid/err=%b exp 100", {done, out_valid, err});
        end
        tick();
        tests_run++;
        if ({done, busy, out_valid} !== 3'b000) begin
            tests_failed++;
            $display("FAIL empty_idle got done/busy/valid=%b exp 000", {done, busy, out_valid});
        end
        out_ready = 1'b0;
    endtask

    task automatic test_read_collision();
        logic [31:0] old_v;
        logic [31:0] new_v;
        int          dc;
        bit          to;
        old_v = $urandom;
        new_v = ~old_v;
        write_line(2, old_v);
        out_ready  = 1'b0;
        start      = 1'b1;
        opcode_in  = 2'b01;
        first_lane = 4'd2;
        lane_count = 5'd1;
        tick();
        start   = 1'b0;
        wr_en   = 1'b1;
        wr_addr = 4'd2;
        wr_data = new_v;
        tick();
        wr_en = 1'b0;
        model_mem[2] = new_v;
        tests_run++;
        if (!out_valid || {out_a, out_b} !== old_v) begin
            tests_failed++;
            $display("FAIL collide_old got v=%b data=%h exp v=1 data=%h", out_valid, {out_a, out_b}, old_v);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        tick();
        run_cmd(2, 1, 2'b01, 100, dc, to);
        tests_run++;
        if (to || got_q.size() != 1) begin
            tests_failed++;
            $display("FAIL collide_rerun got beats=%0d timeout=%0b exp beats=1 timeout=0", got_q.size(), to);
        end else if ({got_q[0].a, got_q[0].b} !== new_v) begin
            tests_failed++;
            $display("FAIL collide_new got=%h exp=%h", {got_q[0].a, got_q[0].b}, new_v);
        end
    endtask

    task automatic test_reset_mid_run();
        int dc;
        bit to;
        int waited;
        for (int i = 8; i < 12; i++) write_line(i, $urandom);
        out_ready  = 1'b0;
        start      = 1'b1;
        opcode_in  = 2'b10;
        first_lane = 4'd8;
        lane_count = 5'd4;
        tick();
        start  = 1'b0;
        waited = 0;
        while (!out_valid && waited < 10) begin
            tick();
            waited++;
        end
        rst_n = 1'b0;
        tick();
        tests_run++;
        if ({out_valid, busy, done} !== 3'b000) begin
            tests_failed++;
            $display("FAIL abort got valid/busy/done=%b exp 000", {out_valid, busy, done});
        end
        rst_n = 1'b1;
        tick();
        run_cmd(9, 3, 2'b01, 60, dc, to);
        build_exp(9, 3, 2'b01);
        tests_run++;
        if (to || dc != 1 || got_q.size() != exp_q.size()) begin
            tests_failed++;
            $display("FAIL abort_rerun got beats=%0d done=%0d timeout=%0b exp beats=3 done=1 timeout=0",
                     got_q.size(), dc, to);
        end else begin
            for (int i = 0; i < got_q.size(); i++) begin
                tests_run++;
                if (got_q[i] !== exp_q[i]) begin
                    tests_failed++;
                    $display("FAIL abort_beat%0d got=%h exp=%h", i, got_q[i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_random_runs();
        int         dc;
        bit         to;
        int         first;
        int         count;
        logic [1:0] op;
        for (int i = 0; i < NL; i++) write_line(i, $urandom);
        for (int r = 0; r < 16; r++) begin
            first = $urandom_range(0, NL - 1);
            count = $urandom_range(0, NL);
            op    = 2'($urandom_range(0, 2));
            if ($urandom_range(0, 1) == 1) write_line($urandom_range(0, NL - 1), $urandom);
            run_cmd(first, count, op, $urandom_range(30, 100), dc, to);
            build_exp(first, count, op);
            $display("[TB] run %0d first=%0d count=%0d op=%0d beats=%0d", r, first, count, op, got_q.size());
            tests_run++;
            if (to || dc != 1 || got_q.size() != exp_q.size()) begin
                tests_failed++;
                $display("FAIL rand%0d_count got beats=%0d done=%0d timeout=%0b exp beats=%0d done=1 timeout=0",
                         r, got_q.size(), dc, to, exp_q.size());
            end else begin
                for (int i = 0; i < got_q.size(); i++) begin
                    tests_run++;
                    if (got_q[i] !== exp_q[i]) begin
                        tests_failed++;
                        $display("FAIL rand%0d_beat%0d got=%h exp=%h", r, i, got_q[i], exp_q[i]);
                    end
                end
            end
        end
    endtask

    initial begin
        #2;
        test_reset();
        test_single();
        test_wrap();
        test_backpressure();
        test_err_and_empty();
        test_read_collision();
        test_reset_mid_run();
        test_random_runs();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired after %0d checks", tests_run);
        $fatal(1, "watchdog");
    end

endmodule
